write_master: RTL and testbench
===============================

# write_master

Stream-to-memory capture stage that sits directly downstream of the DDR3 read streamer and the processing chain it feeds. Accepts 16-bit signed samples qualified by a one-cycle valid strobe, buffers them in a small FIFO and writes them to DDR3 through an Avalon-MM write master with waitrequest back-pressure. Software configures and starts it through a 3-bit Avalon-MM CSR slave and polls `done`.

## Interface
- `FIFO_DEPTH`, 16, sample buffer entries; power of two, ≥4
- `ADDR_W`, 32, DDR3 address width
- `clk` in 1 — single clock for all logic
- `rst` in 1 — reset, asynchronous, active-low
- `d_in` in 16 — signed sample from the upstream stream
- `vin` in 1 — `d_in` valid, one-cycle strobe
- `ddr_addr` out 32 — DDR3 write address
- `ddr_write` out 1 — Avalon write request
- `ddr_writedata` out 16 — signed sample to DDR3
- `ddr_waitrequest` in 1 — DDR3 back-pressure
- `addr` in 3 — CSR word address
- `read` / `write` in 1 — CSR strobes
- `writedata` in 32 — CSR write data
- `readdata` out 32 — CSR read data
- `done` out 1 — capture complete

## Operation
- CSR map: 0x0 base address (R/W); 0x1 length in samples (R/W); 0x2 address step (R/W); 0x3 start (W); 0x4 status (R: bit0 done, bit1 busy, bit2 overflow sticky); 0x5 samples written (R); 0x6 overflow count (R, see Configuration); 0x7 soft reset (W). Unmapped reads return 0xDEADBEEF; writes to read-only addresses are ignored.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on start, load `ddr_addr` = base, clear accepted/written counters and the overflow sticky, flush the FIFO, go to RUN. If length = 0, go straight to DONE.
- RUN: each `vin` pushes `d_in` while accepted < length. Samples beyond length are discarded silently. When accepted = length, go to DRAIN.
- RUN/DRAIN: `ddr_write` = FIFO not empty. `ddr_writedata` = FIFO head, show-ahead. On `ddr_write` && !`ddr_waitrequest`: pop the FIFO, add step to `ddr_addr`, increment written.
- DRAIN: when written = length, go to DONE.
- DONE: `done` = 1, `ddr_write` = 0. Start restarts exactly as from IDLE.
- Start in RUN/DRAIN: ignored.
- Overflow: `vin` while the FIFO is full and no pop occurs that cycle drops the sample, sets the sticky bit and does not increment accepted. The capture then completes only after length samples are accepted.
- Soft reset (write 0x7) in any state: return to IDLE and flush the FIFO. `ddr_write` drops next cycle. CSR configuration registers are kept. Software issues it only when not busy.
- Arithmetic: address, counters and step are 32-bit unsigned, wrapping modulo 2^32.

## Timing
- Async reset values: `ddr_addr` 0, `ddr_write` 0, `ddr_writedata` 0, `readdata` 0, `done` 0, base 0, length 0, step 1, state IDLE, FIFO empty.
- CSR read latency: 1 cycle. `readdata` is registered on the cycle `read` is high.
- Start write in cycle t: state = RUN in cycle t+1. `vin` in t+1 is accepted.
- `vin` in cycle t (FIFO empty): `ddr_write` high in t+1, with the data/address of that sample.
- While `ddr_waitrequest` = 1: `ddr_write`, `ddr_addr` and `ddr_writedata` hold stable.
- Throughput: 1 sample/cycle with no back-pressure.
- `done` rises the cycle after the final accepted write.
- Busy = state is RUN or DRAIN.

## Configuration
- `WRITE_MASTER_OVF_CNT_EN` defined: a 32-bit saturating counter of dropped samples, cleared on start, readable at 0x6.
- Macro undefined: the counter is absent and 0x6 reads 0xDEADBEEF. The overflow sticky bit exists in both builds.

## Structure
- Package `write_master_pkg`: CSR address constants, state enum (IDLE/RUN/DRAIN/DONE), the 0xDEADBEEF default-read constant.
- Sub-module `write_master_fifo`: synchronous show-ahead FIFO, `FIFO_DEPTH` × 16, with push, pop, full, empty and flush. Simultaneous push and pop when full is allowed.
- Top level holds the CSRs, FSM, counters and Avalon master.

## Test plan
- Base 0x100, length 4, step 2, `vin` every cycle, no waitrequest → writes to 0x100/0x102/0x104/0x106 with data in order; `done` = 1; 0x5 reads 4.
- Same setup, `ddr_waitrequest` high for 3 cycles on the 2nd write → addr/data held stable 3 cycles; no loss; 4 writes total.
- Depth 16, waitrequest held high, 20 back-to-back `vin` → 16 buffered (17 if a pop coincides); status bit2 = 1; with the macro, 0x6 reads the drop count.
- Length 0, start → DONE next cycle with no `ddr_write`; length 3 with 5 `vin` → only the first 3 written.
- Soft reset mid-RUN after 2 writes → IDLE, `ddr_write` = 0, base/length/step unchanged. Restart → fresh count from base.
- Async `rst` low mid-write → all outputs 0, step reads 1, state IDLE immediately without a clock.

Source files
------------

// File: rtl/write_master_pkg.sv
// Shared definitions for the write_master capture stage: CSR word addresses,
// the capture state encoding and the value returned for unmapped CSR reads.
// Ports: none (package only).
package write_master_pkg;

  localparam logic [2:0] CSR_BASE    = 3'h0;
  localparam logic [2:0] CSR_LEN     = 3'h1;
  localparam logic [2:0] CSR_STEP    = 3'h2;
  localparam logic [2:0] CSR_START   = 3'h3;
  localparam logic [2:0] CSR_STATUS  = 3'h4;
  localparam logic [2:0] CSR_WRITTEN = 3'h5;
  localparam logic [2:0] CSR_OVF_CNT = 3'h6;
  localparam logic [2:0] CSR_SRST    = 3'h7;

  localparam logic [31:0] RD_DEFAULT = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/write_master_fifo.sv
// Show-ahead sample FIFO: head is valid combinationally whenever not empty.
// Latency: push visible at head the cycle after; pop takes effect at the edge.
// Backpressure: push ignored when full unless a pop happens the same cycle; flush wins over both.
// Ports: clk, rst (async active-low), flush, push/push_data, pop, head, full, empty.
module write_master_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/write_master.sv
// Stream-to-DDR3 capture: buffers 16-bit samples and writes them out via an Avalon-MM master.
// Latency: vin in cycle t presents ddr_write in t+1; CSR reads return one cycle after read.
// Backpressure: ddr_waitrequest freezes addr/data/write; a full FIFO drops samples (sticky flag).
// Ports: clk, rst (async active-low); stream d_in/vin; Avalon master ddr_*; CSR slave addr/read/
// write/writedata/readdata; done. Optional WRITE_MASTER_OVF_CNT_EN adds a dropped-sample counter at 0x6.
module write_master
  import write_master_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] d_in,
  input  logic               vin,
  output logic [ADDR_W-1:0]  ddr_addr,
  output logic               ddr_write,
  output logic signed [15:0] ddr_writedata,
  input  logic               ddr_waitrequest,
  input  logic [2:0]         addr,
  input  logic               read,
  input  logic               write,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               done
);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       len_q;
  logic [31:0]       step_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       acc_q;
  logic [31:0]       wr_q;
  logic [31:0]       acc_nxt;
  logic [31:0]       wr_nxt;
  logic              ovf_q;

  logic              busy;
  logic              start_ok;
  logic              srst;
  logic              take;
  logic              push;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [15:0]       fifo_head;

  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  // Start is only honoured between captures; a start while busy is ignored.
  assign start_ok = write && (addr == CSR_START) && ((state_q == IDLE) || (state_q == DONE));
  assign srst     = write && (addr == CSR_SRST);

  assign ddr_write     = busy && !fifo_empty;
  assign ddr_writedata = ddr_write ? fifo_head : '0;
  assign ddr_addr      = addr_q;
  assign done          = (state_q == DONE);

  assign pop  = ddr_write && !ddr_waitrequest;
  // Samples past the programmed length are discarded without counting as overflow.
  assign take = (state_q == RUN) && vin && (acc_q < len_q);
  assign push = take && (!fifo_full || pop);
  assign drop = take && fifo_full && !pop;

  assign acc_nxt = acc_q + {31'd0, push};
  assign wr_nxt  = wr_q + {31'd0, pop};

  write_master_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (16)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (start_ok || srst),
    .push      (push),
    .push_data (d_in),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Transitions look at next-cycle counter values so done rises the cycle
  // after the final write handshake rather than two cycles later.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_ok) state_d = (len_q == '0) ? DONE : RUN;
      end
      RUN: begin
        if (acc_nxt == len_q) state_d = (wr_nxt == len_q) ? DONE : DRAIN;
      end
      DRAIN: begin
        if (wr_nxt == len_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (srst) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q <= '0;
      len_q  <= '0;
      step_q <= 32'd1;
    end else if (write) begin
      case (addr)
        CSR_BASE: base_q <= ADDR_W'(writedata);
        CSR_LEN:  len_q  <= writedata;
        CSR_STEP: step_q <= writedata;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      acc_q  <= '0;
      wr_q   <= '0;
      ovf_q  <= 1'b0;
    end else if (start_ok) begin
      addr_q <= base_q;
      acc_q  <= '0;
      wr_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) acc_q <= acc_nxt;
      if (pop) begin
        addr_q <= addr_q + ADDR_W'(step_q);
        wr_q   <= wr_nxt;
      end
      if (drop) ovf_q <= 1'b1;
    end
  end

`ifdef WRITE_MASTER_OVF_CNT_EN
  logic [31:0] ovf_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt_q <= '0;
    end else if (start_ok) begin
      ovf_cnt_q <= '0;
    end else if (drop && (ovf_cnt_q != '1)) begin
      ovf_cnt_q <= ovf_cnt_q + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      readdata <= '0;
    end else if (read) begin
      case (addr)
        CSR_BASE:    readdata <= 32'(base_q);
        CSR_LEN:     readdata <= len_q;
        CSR_STEP:    readdata <= step_q;
        CSR_STATUS:  readdata <= {29'd0, ovf_q, busy, done};
        CSR_WRITTEN: readdata <= wr_q;
`ifdef WRITE_MASTER_OVF_CNT_EN
        CSR_OVF_CNT: readdata <= ovf_cnt_q;
`else
        CSR_OVF_CNT: readdata <= RD_DEFAULT;
`endif
        default:     readdata <= RD_DEFAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_write_master.sv
module tb_write_master;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] d_in = '0;
  logic        vin = 1'b0;
  logic [31:0] ddr_addr;
  logic        ddr_write;
  logic [15:0] ddr_writedata;
  logic        ddr_waitrequest = 1'b0;
  logic [2:0]  addr = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        done;

  always #5 clk = ~clk;

  write_master #(.FIFO_DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .d_in            (d_in),
    .vin             (vin),
    .ddr_addr        (ddr_addr),
    .ddr_write       (ddr_write),
    .ddr_writedata   (ddr_writedata),
    .ddr_waitrequest (ddr_waitrequest),
    .addr            (addr),
    .read            (read),
    .write           (write),
    .writedata       (writedata),
    .readdata        (readdata),
    .done            (done)
  );

  typedef struct {
    logic [31:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t e;
  int  total = 0;
  int  bad   = 0;

  // waitrequest modes: 0 never, 1 random, 2 stall the 2nd write, 3 always
  int          mode = 0;
  int          stall_left = 0;
  int          stall_seen = 0;
  int          hs_cnt = 0;
  int          wr_seen = 0;
  bit          stab_en = 1'b1;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_a = '0;
  logic [15:0] prev_d = '0;

  // reference model of one capture
  bit          m_active = 1'b0;
  bit          m_hold = 1'b0;
  logic [31:0] m_base = '0;
  logic [31:0] m_step = '0;
  logic [31:0] m_len = '0;
  logic [31:0] m_acc = '0;
  int          m_occ = 0;
  int          m_drops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // waitrequest driver and write monitor
  initial begin
    forever begin
      @(negedge clk);
      case (mode)
        1: ddr_waitrequest = ($urandom_range(0, 3) == 0);
        2: begin
          ddr_waitrequest = 1'b0;
          if (ddr_write && hs_cnt == 1 && stall_left > 0) begin
            ddr_waitrequest = 1'b1;
            stall_left--;
            stall_seen++;
          end
        end
        3: ddr_waitrequest = 1'b1;
        default: ddr_waitrequest = 1'b0;
      endcase
      if (rst) begin
        if (stab_en && prev_hold) begin
          chk("hold_write", {31'd0, ddr_write}, 32'd1);
          chk("hold_addr", ddr_addr, prev_a);
          chk("hold_data", {16'd0, ddr_writedata}, {16'd0, prev_d});
        end
        if (ddr_write) wr_seen++;
        if (ddr_write && !ddr_waitrequest) begin
          hs_cnt++;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got addr 0x%08h data 0x%04h, none expected", ddr_addr, ddr_writedata);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", ddr_addr, e.a);
            chk("wr_data", {16'd0, ddr_writedata}, {16'd0, e.d});
          end
        end
      end
      prev_hold = rst && ddr_write && ddr_waitrequest;
      prev_a = ddr_addr;
      prev_d = ddr_writedata;
    end
  end

  // All driving tasks start and end at posedge+1.
  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    addr = a;
    writedata = d;
    write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    addr = a;
    read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    d = readdata;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] v;
    csr_read(a, v);
    chk(name, v, exp);
  endtask

  task automatic do_start(input logic [31:0] b, input logic [31:0] l, input logic [31:0] s);
    csr_write(3'h0, b);
    csr_write(3'h1, l);
    csr_write(3'h2, s);
    m_base = b;
    m_len = l;
    m_step = s;
    m_acc = '0;
    m_occ = 0;
    m_drops = 0;
    m_active = (l != 0);
    hs_cnt = 0;
    csr_write(3'h3, 32'd1);
  endtask

  task automatic send_vin(input logic [15:0] d);
    vin = 1'b1;
    d_in = d;
    if (m_active && m_acc < m_len) begin
      if (m_hold && m_occ >= DEPTH) begin
        m_drops++;
      end else begin
        exp_q.push_back('{m_base + m_acc * m_step, d});
        m_acc++;
        m_occ++;
      end
    end
    @(posedge clk); #1;
    vin = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!(done && exp_q.size() == 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_done"}, {31'd0, done}, 32'd1);
    chk({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic wait_q_empty(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] rb;
    logic [31:0] rs;
    logic [31:0] rl;
    int guard;
    #2 rst = 1'b0;
    #10;
    chk("rst_ddr_write", {31'd0, ddr_write}, 32'd0);
    chk("rst_ddr_addr", ddr_addr, 32'd0);
    chk("rst_ddr_wdata", {16'd0, ddr_writedata}, 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_cycle();
    rd_chk("rst_step", 3'h2, 32'd1);
    rd_chk("rst_base", 3'h0, 32'd0);
    rd_chk("rst_len", 3'h1, 32'd0);
    rd_chk("rst_status", 3'h4, 32'd0);
    rd_chk("rd_start_reg", 3'h3, 32'hDEADBEEF);
`ifdef WRITE_MASTER_OVF_CNT_EN
    rd_chk("rst_ovf_cnt", 3'h6, 32'd0);
`else
    rd_chk("rd_ovf_cnt_absent", 3'h6, 32'hDEADBEEF);
`endif

    // basic capture, exact done timing
    do_start(32'h100, 32'd4, 32'd2);
    for (int i = 0; i < 4; i++) send_vin(16'h8000 + 16'(i * 16'h1111));
    chk("t1_done_early", {31'd0, done}, 32'd0);
    idle_cycle();
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_drained", exp_q.size(), 32'd0);
    chk("t1_write_low", {31'd0, ddr_write}, 32'd0);
    rd_chk("t1_written", 3'h5, 32'd4);
    rd_chk("t1_status", 3'h4, 32'd1);

    // 3-cycle stall on the second write
    mode = 2;
    stall_left = 3;
    stall_seen = 0;
    do_start(32'h100, 32'd4, 32'd2);
    for (int i = 0; i < 4; i++) send_vin(16'(i + 7));
    wait_done(50, "t2");
    chk("t2_stall_cycles", stall_seen, 32'd3);
    mode = 0;
    csr_write(3'h5, 32'd99);
    rd_chk("t2_written_ro", 3'h5, 32'd4);

    // overflow: waitrequest held, 20 back-to-back samples into a 16-deep FIFO
    mode = 3;
    m_hold = 1'b1;
    do_start(32'h2000, 32'd18, 32'd4);
    for (int i = 0; i < 20; i++) send_vin(16'($urandom));
    rd_chk("t3_status_ovf", 3'h4, 32'd6);
`ifdef WRITE_MASTER_OVF_CNT_EN
    rd_chk("t3_ovf_cnt", 3'h6, 32'(m_drops));
`else
    rd_chk("t3_ovf_cnt_absent", 3'h6, 32'hDEADBEEF);
`endif
    m_hold = 1'b0;
    mode = 0;
    send_vin(16'h1234);
    send_vin(16'hFEDC);
    wait_done(100, "t3");
    rd_chk("t3_status_done", 3'h4, 32'd5);
    rd_chk("t3_written", 3'h5, 32'd18);

    // zero length
    guard = wr_seen;
    do_start(32'h300, 32'd0, 32'd1);
    chk("t4_done_len0", {31'd0, done}, 32'd1);
    chk("t4_no_write", {31'd0, ddr_write}, 32'd0);
    send_vin(16'h5555);
    send_vin(16'h6666);
    chk("t4_no_writes_seen", wr_seen, guard);
    rd_chk("t4_written", 3'h5, 32'd0);

    // only the first 3 of 5 samples are written
    do_start(32'h400, 32'd3, 32'd1);
    for (int i = 0; i < 5; i++) send_vin(16'(16'hA0 + i));
    wait_done(50, "t5");
    rd_chk("t5_written", 3'h5, 32'd3);

    // soft reset mid-RUN after 2 writes
    do_start(32'h500, 32'd8, 32'd3);
    send_vin(16'h0101);
    send_vin(16'h0202);
    wait_q_empty(20, "t6_two_writes");
    mode = 3;
    m_hold = 1'b1;
    m_occ = 0;
    send_vin(16'h0303);
    send_vin(16'h0404);
    chk("t6_write_pending", {31'd0, ddr_write}, 32'd1);
    stab_en = 1'b0;
    csr_write(3'h7, 32'd1);
    chk("t6_write_dropped", {31'd0, ddr_write}, 32'd0);
    chk("t6_not_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    m_active = 1'b0;
    m_hold = 1'b0;
    mode = 0;
    rd_chk("t6_status", 3'h4, 32'd0);
    stab_en = 1'b1;
    rd_chk("t6_base", 3'h0, 32'h500);
    rd_chk("t6_len", 3'h1, 32'd8);
    rd_chk("t6_step", 3'h2, 32'd3);
    do_start(32'h500, 32'd8, 32'd3);
    for (int i = 0; i < 8; i++) send_vin(16'(16'h0F00 + i));
    wait_done(50, "t6_restart");
    rd_chk("t6_written", 3'h5, 32'd8);

    // randomized captures with random back-pressure
    mode = 1;
    for (int it = 0; it < 6; it++) begin
      rb = $urandom;
      rs = $urandom;
      rl = 32'($urandom_range(1, DEPTH));
      do_start(rb, rl, rs);
      guard = 0;
      while (m_acc < rl && guard < 300) begin
        if ($urandom_range(0, 2) != 0) send_vin(16'($urandom));
        else idle_cycle();
        guard++;
      end
      send_vin(16'($urandom));
      send_vin(16'($urandom));
      wait_done(400, "rand");
      rd_chk("rand_written", 3'h5, rl);
      rd_chk("rand_status", 3'h4, 32'd1);
    end
    mode = 0;
    idle_cycle();

    // async reset while a write is held
    mode = 3;
    do_start(32'h40, 32'd4, 32'd1);
    send_vin(16'h1234);
    chk("t7_write_high", {31'd0, ddr_write}, 32'd1);
    chk("t7_addr", ddr_addr, 32'h40);
    rd_chk("t7_base", 3'h0, 32'h40);
    stab_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t7_arst_write", {31'd0, ddr_write}, 32'd0);
    chk("t7_arst_addr", ddr_addr, 32'd0);
    chk("t7_arst_wdata", {16'd0, ddr_writedata}, 32'd0);
    chk("t7_arst_readdata", readdata, 32'd0);
    chk("t7_arst_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    m_active = 1'b0;
    mode = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle_cycle();
    stab_en = 1'b1;
    rd_chk("t7_step", 3'h2, 32'd1);
    rd_chk("t7_base_rst", 3'h0, 32'd0);
    rd_chk("t7_status", 3'h4, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
